dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined CPU's MEM-stage port (mem_w/addr/wdata/dm_ctrl -> rdata).
//  - Zero-latency read; writes commit on the clock edge.
//  - Handles byte, halfword and word accesses with sign/zero extension.
//  - Also decodes a small MMIO window: free-running cycle counter, LED register, store counter,
//    and a sticky misalignment flag, so test programs are observable on the board.
// PARAMETERS
//  ADDR_WIDTH  8             word-address bits of RAM (2**ADDR_WIDTH 32-bit words)
//  MMIO_BASE   32'hFFFF_0000 base of MMIO window; addr[31:8]==MMIO_BASE[31:8] selects MMIO
// PORTS
//  clk         in   1   core clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  mem_w       in   1   store strobe for the current MEM-stage access
//  addr_in     in   32  byte address (CPU ALU result)
//  wdata_in    in   32  store data; low byte/half used for sb/sh
//  dm_ctrl     in   3   0=word 1=half 2=half-unsigned 3=byte 4=byte-unsigned; 5-7 treated as word
//  rdata_out   out  32  load data, extended per dm_ctrl
//  led_out     out  16  LED register
//  misalign    out  1   sticky: set by any misaligned access; cleared by reset or MMIO write
// BEHAVIOUR
//  Reset (async, immediate): LED register=0, cycle counter=0, store counter=0, misalign=0.
//   - RAM is not cleared by reset; it is zero-initialised at time 0 only.
//  Read path: purely combinational from addr_in/dm_ctrl to rdata_out, same cycle.
//   - RAM lane select: addr[1:0] for bytes, addr[1] for halves, little-endian.
//   - dm_ctrl 1/3: sign-extend; 2/4: zero-extend.
//   - Reads are side-effect free: mem_w=0 never changes state.
//  Write path: when mem_w=1 at the rising edge, only the selected lanes are updated.
//   - word: 4 lanes; half: 2 lanes at addr[1]; byte: 1 lane at addr[1:0].
//  Read-during-write, same address, same cycle: rdata_out shows the OLD contents.
//   - The new value is visible from the next cycle.
//  RAM index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing/wrap) outside MMIO.
//  Misaligned access (word with addr[1:0]!=0, half with addr[0]!=0):
//   - Write suppressed; reads return 0.
//   - misalign is set on the next edge (regardless of mem_w).
//  MMIO window (addr[7:0]; word accesses only, other sizes read 0 and do not write):
//   - 0x00 CYCLE: read = cycle counter; +1 every cycle, wraps 32'hFFFFFFFF->0; writes ignored.
//   - 0x04 LED: read = {16'b0,led}; write loads wdata[15:0].
//   - 0x08 STORES: read = count of committed RAM stores (not MMIO or suppressed ones), wraps; a write clears it.
//   - 0x0C STATUS: read = {31'b0,misalign}; any write clears misalign.
//     If the same cycle also has a misaligned access, set wins.
//   - Other MMIO offsets: read 0, writes dropped.
//  MMIO access never touches RAM.
//  Reset asserted mid-cycle clears MMIO state at once; a store in that cycle is dropped.
// TESTING
//  - sw 32'h8badf00d @0x10, then lw @0x10 -> 8badf00d; lbu @0x13 -> 0000008b; lb @0x13 -> ffffff8b.
//  - sh 16'hbeef @0x22 over word 0 -> word@0x20 = beef0000; lh @0x22 -> ffffbeef; lhu -> 0000beef.
//  - sw 0x11 @0x40 with lw @0x40 same cycle -> rdata old value; next cycle -> 00000011.
//  - sw @0x41 -> RAM unchanged, misalign=1 next cycle; sw any @MMIO+0x0C -> misalign=0.
//  - After reset release, lw MMIO+0x00 at cycles 3 and 8 differs by 5.
//  - 3 RAM stores + 1 LED write (wdata 0x1234) -> STORES=3, led_out=1234.
//  - Assert reset mid-run -> led_out/misalign clear the same cycle, without a clock edge.

Source files
------------

// File: rtl/dmem_responder.sv
// MEM-stage data memory: zero-latency reads, edge-committed byte/half/word stores,
// plus a small MMIO window (cycle counter, LEDs, store counter, sticky misalign flag).
module dmem_responder #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata_out,
  output logic [15:0] led_out,
  output logic        misalign
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

  // RAM has no reset; contents rely on the device's power-up zero state.
  logic [31:0] mem [DEPTH];

  logic [31:0] cycle_cnt;
  logic [31:0] store_cnt;
  logic [15:0] led;

  size_t                 size;
  logic                  is_mmio;
  logic                  misal;
  logic [ADDR_WIDTH-1:0] idx;
  logic [7:0]            off;
  logic [31:0]           ram_word;
  logic [31:0]           wd_lanes;
  logic [3:0]            be;
  logic                  ram_we;
  logic                  mmio_we;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  ctrl);
    logic signed [15:0] h;
    logic signed [7:0]  b;
    h = lane[1] ? word[31:16] : word[15:0];
    b = word[8*lane +: 8];
    case (ctrl)
      3'd1:    return 32'(h);
      3'd2:    return {16'b0, h};
      3'd3:    return 32'(b);
      3'd4:    return {24'b0, b};
      default: return word;
    endcase
  endfunction

  always_comb begin
    case (dm_ctrl)
      3'd1, 3'd2: size = SZ_HALF;
      3'd3, 3'd4: size = SZ_BYTE;
      default:    size = SZ_WORD;
    endcase
  end

  assign is_mmio  = (addr_in[31:8] == MMIO_BASE[31:8]);
  assign misal    = ((size == SZ_WORD) && (addr_in[1:0] != 2'b00)) ||
                    ((size == SZ_HALF) && addr_in[0]);
  assign idx      = addr_in[ADDR_WIDTH+1:2];
  assign off      = addr_in[7:0];
  assign ram_word = mem[idx];
  assign ram_we   = mem_w && !is_mmio && !misal;
  assign mmio_we  = mem_w && is_mmio && (size == SZ_WORD) && !misal;
  assign led_out  = led;

  always_comb begin
    be       = 4'b0000;
    wd_lanes = wdata_in;
    case (size)
      SZ_HALF: begin
        be       = addr_in[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata_in[15:0]}};
      end
      SZ_BYTE: begin
        be       = 4'b0001 << addr_in[1:0];
        wd_lanes = {4{wdata_in[7:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    rdata_out = 32'b0;
    if (misal) begin
      rdata_out = 32'b0;
    end else if (is_mmio) begin
      if (size == SZ_WORD) begin
        case (off)
          8'h00:   rdata_out = cycle_cnt;
          8'h04:   rdata_out = {16'b0, led};
          8'h08:   rdata_out = store_cnt;
          8'h0C:   rdata_out = {31'b0, misalign};
          default: rdata_out = 32'b0;
        endcase
      end
    end else begin
      rdata_out = extend_load(ram_word, addr_in[1:0], dm_ctrl);
    end
  end

  // A store coinciding with a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wd_lanes[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= 32'b0;
      store_cnt <= 32'b0;
      led       <= 16'b0;
      misalign  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (ram_we)
        store_cnt <= store_cnt + 32'd1;
      else if (mmio_we && off == 8'h08)
        store_cnt <= 32'b0;
      if (mmio_we && off == 8'h04)
        led <= wdata_in[15:0];
      // Set has priority over a STATUS-write clear.
      if (misal)
        misalign <= 1'b1;
      else if (mmio_we && off == 8'h0C)
        misalign <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table for load/store lanes, plus
// hand sequences for MMIO, misalignment, cycle counter and asynchronous reset.
module tb_dmem_responder;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata_out;
  logic [15:0] led_out;
  logic        misalign;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
    logic [31:0] exp;
    logic        chk;
  } vec_t;

  vec_t tv[$];

  dmem_responder #(.ADDR_WIDTH(8), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .mem_w(mem_w), .addr_in(addr_in),
    .wdata_in(wdata_in), .dm_ctrl(dm_ctrl), .rdata_out(rdata_out),
    .led_out(led_out), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] c, input logic [31:0] exp, input logic chk);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.c = c; v.exp = exp; v.chk = chk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c);
    @(negedge clk);
    mem_w = w; addr_in = a; wdata_in = d; dm_ctrl = c;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 3'd0);
  endtask

  logic [31:0] c1;

  initial begin
    reset = 1'b1; mem_w = 1'b0; addr_in = MB; wdata_in = 32'h0; dm_ctrl = 3'd0;
    #1;
    chk("reset_led", {16'b0, led_out}, 32'h0);
    chk("reset_misalign", {31'b0, misalign}, 32'h0);
    chk("reset_cycle", rdata_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    tv.push_back(mk(1, 32'h20, 32'h0000_0000, 3'd0, 32'h0, 0));
    tv.push_back(mk(1, 32'h10, 32'h8bad_f00d, 3'd0, 32'h0, 0));
    tv.push_back(mk(0, 32'h10, 32'h0, 3'd0, 32'h8bad_f00d, 1));
    tv.push_back(mk(0, 32'h13, 32'h0, 3'd4, 32'h0000_008b, 1));
    tv.push_back(mk(0, 32'h13, 32'h0, 3'd3, 32'hffff_ff8b, 1));
    tv.push_back(mk(0, 32'h10, 32'h0, 3'd2, 32'h0000_f00d, 1));
    tv.push_back(mk(0, 32'h10, 32'h0, 3'd1, 32'hffff_f00d, 1));
    tv.push_back(mk(0, 32'h10, 32'h0, 3'd4, 32'h0000_000d, 1));
    tv.push_back(mk(0, 32'h11, 32'h0, 3'd3, 32'hffff_fff0, 1));
    tv.push_back(mk(0, 32'h12, 32'h0, 3'd1, 32'hffff_8bad, 1));
    tv.push_back(mk(1, 32'h22, 32'h1234_beef, 3'd1, 32'h0, 0));
    tv.push_back(mk(0, 32'h20, 32'h0, 3'd0, 32'hbeef_0000, 1));
    tv.push_back(mk(0, 32'h22, 32'h0, 3'd1, 32'hffff_beef, 1));
    tv.push_back(mk(0, 32'h22, 32'h0, 3'd2, 32'h0000_beef, 1));
    tv.push_back(mk(1, 32'h21, 32'haaaa_aa5a, 3'd3, 32'h0, 0));
    tv.push_back(mk(0, 32'h20, 32'h0, 3'd0, 32'hbeef_5a00, 1));
    tv.push_back(mk(1, 32'h40, 32'h0000_0077, 3'd0, 32'h0, 0));
    tv.push_back(mk(1, 32'h40, 32'h0000_0011, 3'd0, 32'h0000_0077, 1));
    tv.push_back(mk(0, 32'h40, 32'h0, 3'd0, 32'h0000_0011, 1));
    tv.push_back(mk(0, 32'h410, 32'h0, 3'd0, 32'h8bad_f00d, 1));
    tv.push_back(mk(0, 32'h10, 32'h0, 3'd7, 32'h8bad_f00d, 1));

    foreach (tv[i]) begin
      step(tv[i].w, tv[i].a, tv[i].d, tv[i].c);
      if (tv[i].chk) chk($sformatf("vec%0d", i), rdata_out, tv[i].exp);
    end
    chk("table_no_misalign", {31'b0, misalign}, 32'h0);

    // Store counter and LED register
    step(1, MB + 32'h08, 32'h0, 3'd0);
    step(1, 32'h80, 32'h1, 3'd0);
    step(1, 32'h84, 32'h2, 3'd0);
    step(1, 32'h88, 32'h3, 3'd3);
    step(1, MB + 32'h04, 32'h0000_1234, 3'd0);
    step(0, MB + 32'h08, 32'h0, 3'd0);
    chk("stores_3", rdata_out, 32'h3);
    chk("led_out", {16'b0, led_out}, 32'h0000_1234);
    step(0, MB + 32'h04, 32'h0, 3'd0);
    chk("led_read", rdata_out, 32'h0000_1234);

    // Misaligned store: suppressed, read 0, flag set on the edge
    step(1, 32'h41, 32'hdead_beef, 3'd0);
    chk("misal_rdata0", rdata_out, 32'h0);
    chk("misal_not_yet", {31'b0, misalign}, 32'h0);
    step(0, 32'h40, 32'h0, 3'd0);
    chk("misal_set", {31'b0, misalign}, 32'h1);
    chk("misal_ram_kept", rdata_out, 32'h0000_0011);
    step(0, MB + 32'h0C, 32'h0, 3'd0);
    chk("status_read", rdata_out, 32'h1);
    step(0, 32'h23, 32'h0, 3'd1);
    chk("misal_half_rd", rdata_out, 32'h0);
    step(0, MB + 32'h08, 32'h0, 3'd0);
    chk("stores_not_misal", rdata_out, 32'h3);
    step(1, MB + 32'h0C, 32'h0, 3'd0);
    idle();
    chk("status_clear", {31'b0, misalign}, 32'h0);

    // MMIO corner cases
    step(0, MB + 32'h04, 32'h0, 3'd4);
    chk("mmio_byte_rd0", rdata_out, 32'h0);
    step(1, MB + 32'h04, 32'h0, 3'd1);
    step(1, MB + 32'h10, 32'hffff_ffff, 3'd0);
    chk("mmio_unmapped_rd0", rdata_out, 32'h0);
    idle();
    chk("mmio_half_no_write", {16'b0, led_out}, 32'h0000_1234);
    step(0, 32'h10, 32'h0, 3'd0);
    chk("mmio_no_ram", rdata_out, 32'h8bad_f00d);
    step(0, MB + 32'h08, 32'h0, 3'd0);
    chk("mmio_not_counted", rdata_out, 32'h3);

    // Asynchronous reset mid-cycle; store in that cycle dropped
    step(1, 32'h41, 32'h0, 3'd0);
    idle();
    chk("pre_reset_misal", {31'b0, misalign}, 32'h1);
    step(1, 32'h10, 32'h0, 3'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_led_clear", {16'b0, led_out}, 32'h0);
    chk("async_misal_clear", {31'b0, misalign}, 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_w = 1'b0;
    step(0, 32'h10, 32'h0, 3'd0);
    chk("reset_store_dropped", rdata_out, 32'h8bad_f00d);
    step(0, MB + 32'h08, 32'h0, 3'd0);
    chk("reset_stores_zero", rdata_out, 32'h0);

    // Cycle counter advances one per clock
    step(0, MB, 32'h0, 3'd0);
    c1 = rdata_out;
    for (int i = 0; i < 4; i++) idle();
    step(0, MB, 32'h0, 3'd0);
    chk("cycle_delta5", rdata_out - c1, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
